// File: rtl/nab_reg_pkg.sv
// Shared definitions for the bridge control/status register file.
// Holds the register byte offsets, AXI response codes, the read/write
// handshake FSM state encodings and the per-register RW/RO attribute mask.
// No ports; imported by axi_lite_reg_responder.
package nab_reg_pkg;

  // Register byte offsets (decode uses offset >> 2)
  localparam int unsigned CHAR_SELECT_REG    = 'h00;
  localparam int unsigned NETWORK_OUTPUT_REG = 'h04;
  localparam int unsigned DIRECT_CTRL_REG    = 'h08;
  localparam int unsigned DEBUG_REG          = 'h0C;
  localparam int unsigned AUX0_REG           = 'h10;
  localparam int unsigned AUX1_REG           = 'h14;
  localparam int unsigned AUX2_REG           = 'h18;
  localparam int unsigned AUX3_REG           = 'h1C;
  localparam int unsigned PWM_CLK_DIV_REG    = 'h20;
  localparam int unsigned PWM_DUTY_REG       = 'h24;
  localparam int unsigned PWM_CLK_CNTR_REG   = 'h28;
  localparam int unsigned PMOD_DAC_REG       = 'h2C;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Bit i set => word register i is writable (0,2,3,8,9,11)
  localparam logic [11:0] REG_RW_MASK = 12'hB0D;

  typedef enum logic [2:0] {
    W_IDLE   = 3'd0,
    W_ADDR   = 3'd1,
    W_DATA   = 3'd2,
    W_COMMIT = 3'd3,
    W_RESP   = 3'd4
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi_lite_wstrb_merge.sv
// Combinational byte-lane merge for AXI write strobes.
// Ports:
//   old_data - current register contents
//   wdata    - incoming write data
//   wstrb    - byte enables, one per byte lane of wdata
//   merged   - wdata bytes where the strobe is set, old_data bytes elsewhere
module axi_lite_wstrb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_data,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   merged
);

  for (genvar b = 0; b < DATA_WIDTH / 8; b++) begin : g_byte
    assign merged[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : old_data[8*b +: 8];
  end

endmodule

// File: rtl/axi_lite_reg_responder.sv
// AXI4-Lite responder for the bridge control/status register file.
// Drives RW control registers to the datapath (PWM, PMOD DAC, debug) and
// returns live status inputs (network output, XADC aux, PWM counter) on reads.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET   - clock, asynchronous active-high reset
//   S_AXI_AW*, S_AXI_W*, S_AXI_B* - write address/data/response channels
//   S_AXI_AR*, S_AXI_R*           - read address/data channels
//   *_reg outputs                 - RW register contents
//   pmod_dac_wr_pulse             - one-cycle pulse after each write to 0x2C
//   network_output, aux0..3, pwm_clk_cntr - RO status inputs
// Build option: define AXI_ERR_RESP_EN to answer out-of-range accesses with
// SLVERR; otherwise they complete with OKAY (reads return 0 either way).
//
// Write FSM
//   state    | meaning
//   W_IDLE   | AWREADY and WREADY high, waiting for either channel
//   W_ADDR   | address latched, waiting for write data
//   W_DATA   | data latched, waiting for write address
//   W_COMMIT | one cycle: register update, response code computed
//   W_RESP   | BVALID high until BREADY
// Read FSM
//   state    | meaning
//   R_IDLE   | ARREADY high, waiting for read address
//   R_DATA   | RVALID high, RDATA held until RREADY
module axi_lite_reg_responder
  import nab_reg_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 9,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS           = 12
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   char_select_reg,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   direct_ctrl_reg,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   debug_reg,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   pwm_clk_div_reg,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   pwm_duty_reg,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   pmod_dac_reg,
  output logic                            pmod_dac_wr_pulse,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   network_output,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   aux0,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   aux1,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   aux2,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   aux3,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   pwm_clk_cntr
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

  localparam logic [IDX_W-1:0] IDX_CHAR_SELECT    = IDX_W'(CHAR_SELECT_REG >> 2);
  localparam logic [IDX_W-1:0] IDX_NETWORK_OUTPUT = IDX_W'(NETWORK_OUTPUT_REG >> 2);
  localparam logic [IDX_W-1:0] IDX_DIRECT_CTRL    = IDX_W'(DIRECT_CTRL_REG >> 2);
  localparam logic [IDX_W-1:0] IDX_DEBUG          = IDX_W'(DEBUG_REG >> 2);
  localparam logic [IDX_W-1:0] IDX_AUX0           = IDX_W'(AUX0_REG >> 2);
  localparam logic [IDX_W-1:0] IDX_AUX1           = IDX_W'(AUX1_REG >> 2);
  localparam logic [IDX_W-1:0] IDX_AUX2           = IDX_W'(AUX2_REG >> 2);
  localparam logic [IDX_W-1:0] IDX_AUX3           = IDX_W'(AUX3_REG >> 2);
  localparam logic [IDX_W-1:0] IDX_PWM_CLK_DIV    = IDX_W'(PWM_CLK_DIV_REG >> 2);
  localparam logic [IDX_W-1:0] IDX_PWM_DUTY       = IDX_W'(PWM_DUTY_REG >> 2);
  localparam logic [IDX_W-1:0] IDX_PWM_CLK_CNTR   = IDX_W'(PWM_CLK_CNTR_REG >> 2);
  localparam logic [IDX_W-1:0] IDX_PMOD_DAC       = IDX_W'(PMOD_DAC_REG >> 2);
  localparam logic [IDX_W-1:0] NUM_REGS_IDX       = IDX_W'(NUM_REGS);

  wr_state_t          wr_state;
  rd_state_t          rd_state;
  logic [IDX_W-1:0]   wr_idx;
  logic [DW-1:0]      wr_data;
  logic [DW/8-1:0]    wr_strb;
  logic [DW-1:0]      wr_old;
  logic [DW-1:0]      wr_merged;
  logic [1:0]         wr_resp;
  logic               wr_in_range;
  logic               wr_is_rw;
  logic               wr_commit;
  logic [IDX_W-1:0]   ar_idx;
  logic [DW-1:0]      rd_mux;
  logic [1:0]         rd_resp;
  logic               aw_hs;
  logic               w_hs;
  logic               unused_addr_lsbs;

  // Byte lane bits of the addresses take no part in decode.
  assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs      = S_AXI_WVALID && S_AXI_WREADY;
  assign wr_commit = (wr_state == W_COMMIT);
  assign ar_idx    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  assign wr_in_range = (wr_idx < NUM_REGS_IDX);
  assign wr_is_rw    = wr_in_range && REG_RW_MASK[wr_idx[3:0]];

`ifdef AXI_ERR_RESP_EN
  logic rd_in_range;
  assign rd_in_range = (ar_idx < NUM_REGS_IDX);
  assign wr_resp     = wr_in_range ? RESP_OKAY : RESP_SLVERR;
  assign rd_resp     = rd_in_range ? RESP_OKAY : RESP_SLVERR;
`else
  assign wr_resp = RESP_OKAY;
  assign rd_resp = RESP_OKAY;
`endif

  always_comb begin
    wr_old = '0;
    case (wr_idx)
      IDX_CHAR_SELECT: wr_old = char_select_reg;
      IDX_DIRECT_CTRL: wr_old = direct_ctrl_reg;
      IDX_DEBUG:       wr_old = debug_reg;
      IDX_PWM_CLK_DIV: wr_old = pwm_clk_div_reg;
      IDX_PWM_DUTY:    wr_old = pwm_duty_reg;
      IDX_PMOD_DAC:    wr_old = pmod_dac_reg;
      default:         wr_old = '0;
    endcase
  end

  axi_lite_wstrb_merge #(.DATA_WIDTH(DW)) u_wstrb_merge (
    .old_data (wr_old),
    .wdata    (wr_data),
    .wstrb    (wr_strb),
    .merged   (wr_merged)
  );

  // Read mux; out-of-range indices return zero.
  always_comb begin
    rd_mux = '0;
    case (ar_idx)
      IDX_CHAR_SELECT:    rd_mux = char_select_reg;
      IDX_NETWORK_OUTPUT: rd_mux = network_output;
      IDX_DIRECT_CTRL:    rd_mux = direct_ctrl_reg;
      IDX_DEBUG:          rd_mux = debug_reg;
      IDX_AUX0:           rd_mux = aux0;
      IDX_AUX1:           rd_mux = aux1;
      IDX_AUX2:           rd_mux = aux2;
      IDX_AUX3:           rd_mux = aux3;
      IDX_PWM_CLK_DIV:    rd_mux = pwm_clk_div_reg;
      IDX_PWM_DUTY:       rd_mux = pwm_duty_reg;
      IDX_PWM_CLK_CNTR:   rd_mux = pwm_clk_cntr;
      IDX_PMOD_DAC:       rd_mux = pmod_dac_reg;
      default:            rd_mux = '0;
    endcase
  end

  // Write channel FSM. READY flags are registered, so they come up one cycle
  // after reset release and drop on the edge that completes each handshake.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      wr_state      <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      wr_idx        <= '0;
      wr_data       <= '0;
      wr_strb       <= '0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            wr_idx        <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            wr_data       <= S_AXI_WDATA;
            wr_strb       <= S_AXI_WSTRB;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            wr_state      <= W_COMMIT;
          end else if (aw_hs) begin
            wr_idx        <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b1;
            wr_state      <= W_ADDR;
          end else if (w_hs) begin
            wr_data       <= S_AXI_WDATA;
            wr_strb       <= S_AXI_WSTRB;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b0;
            wr_state      <= W_DATA;
          end else begin
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
          end
        end
        W_ADDR: begin
          if (w_hs) begin
            wr_data      <= S_AXI_WDATA;
            wr_strb      <= S_AXI_WSTRB;
            S_AXI_WREADY <= 1'b0;
            wr_state     <= W_COMMIT;
          end
        end
        W_DATA: begin
          if (aw_hs) begin
            wr_idx        <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            S_AXI_AWREADY <= 1'b0;
            wr_state      <= W_COMMIT;
          end
        end
        W_COMMIT: begin
          S_AXI_BVALID <= 1'b1;
          S_AXI_BRESP  <= wr_resp;
          wr_state     <= W_RESP;
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
            wr_state      <= W_IDLE;
          end
        end
        default: begin
          S_AXI_AWREADY <= 1'b0;
          S_AXI_WREADY  <= 1'b0;
          S_AXI_BVALID  <= 1'b0;
          wr_state      <= W_IDLE;
        end
      endcase
    end
  end

  // Register file update. The DAC strobe fires on any commit to its offset,
  // even when every byte strobe is clear, so the DAC can reload its value.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      char_select_reg   <= '0;
      direct_ctrl_reg   <= '0;
      debug_reg         <= '0;
      pwm_clk_div_reg   <= '0;
      pwm_duty_reg      <= '0;
      pmod_dac_reg      <= '0;
      pmod_dac_wr_pulse <= 1'b0;
    end else begin
      pmod_dac_wr_pulse <= wr_commit && (wr_idx == IDX_PMOD_DAC);
      if (wr_commit && wr_is_rw) begin
        case (wr_idx)
          IDX_CHAR_SELECT: char_select_reg <= wr_merged;
          IDX_DIRECT_CTRL: direct_ctrl_reg <= wr_merged;
          IDX_DEBUG:       debug_reg       <= wr_merged;
          IDX_PWM_CLK_DIV: pwm_clk_div_reg <= wr_merged;
          IDX_PWM_DUTY:    pwm_duty_reg    <= wr_merged;
          IDX_PMOD_DAC:    pmod_dac_reg    <= wr_merged;
          default: ;
        endcase
      end
    end
  end

  // Read channel FSM. RDATA is captured on the AR handshake edge, so a write
  // committing on that same edge is not yet visible in the returned data.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rd_state      <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (S_AXI_ARREADY && S_AXI_ARVALID) begin
            S_AXI_RDATA   <= rd_mux;
            S_AXI_RRESP   <= rd_resp;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_ARREADY <= 1'b0;
            rd_state      <= R_DATA;
          end else begin
            S_AXI_ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
            rd_state      <= R_IDLE;
          end
        end
        default: begin
          S_AXI_RVALID  <= 1'b0;
          S_AXI_ARREADY <= 1'b0;
          rd_state      <= R_IDLE;
        end
      endcase
    end
  end

endmodule
